// File: rtl/conv_pkg.sv
// Shared convolution output-path definitions (conv core, conv_output_fifo, fifo_controller).
package conv_pkg;

    localparam int DATA_W         = 32;
    localparam int OUT_BUS_W      = 128;
    localparam int WORDS_PER_BEAT = OUT_BUS_W / DATA_W;
    localparam int FIFO_ADDR_W    = 4;

    // Accepted-operation class for one FIFO clock edge, encoded as {write, read}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage : conv_pkg

// File: rtl/fifo_dp_ram.sv
// Simple dual-port storage: one write port, one registered read port; the array itself is not reset.
module fifo_dp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A same-address write on this edge is not visible here: the read returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : fifo_dp_ram

// File: rtl/conv_output_fifo.sv
// Result FIFO between the convolution MAC array and fifo_controller, one-cycle registered read.
// Optional build macro FIFO_PEAK_EN adds the peak_level occupancy tracker output.
module conv_output_fifo #(
    parameter int DATA_W    = conv_pkg::DATA_W,
    parameter int ADDR_W    = conv_pkg::FIFO_ADDR_W,
    parameter int AF_MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
`ifdef FIFO_PEAK_EN
    ,
    output logic [ADDR_W:0]   peak_level
`endif
);

    import conv_pkg::*;

    localparam int                LVL_W    = ADDR_W + 1;
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   FULL_LVL = LVL_W'(DEPTH);
    localparam logic [ADDR_W:0]   AF_LVL   = LVL_W'(DEPTH - AF_MARGIN);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] level_nxt;
    logic            wr_acc;
    logic            rd_acc;
    fifo_op_e        op;

    // Flags come only from the registered level, keeping wr_en/rd_en off the output paths.
    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == FULL_LVL);
    assign almost_full = (level >= AF_LVL);

    // A read while full frees a slot on the same edge, so the write is still accepted.
    assign wr_acc = wr_en && (!fifo_full || rd_en) && !clear;
    assign rd_acc = rd_en && !fifo_empty && !clear;
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    always_comb begin
        level_nxt = level;
        if (clear) begin
            level_nxt = '0;
        end else begin
            case (op)
                OP_WR:   level_nxt = level + 1'b1;
                OP_RD:   level_nxt = level - 1'b1;
                default: level_nxt = level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_nxt;
            if (wr_en && fifo_full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_PEAK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_level <= '0;
        end else if (clear) begin
            peak_level <= '0;
        end else if (level_nxt > peak_level) begin
            peak_level <= level_nxt;
        end
    end
`endif

    fifo_dp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

endmodule : conv_output_fifo

// File: tb/tb_conv_output_fifo.sv
// Directed scoreboard bench for conv_output_fifo (DEPTH=16, AF_MARGIN=2); honours FIFO_PEAK_EN.
module tb_conv_output_fifo;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = 14;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic              almost_full;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;
`ifdef FIFO_PEAK_EN
    logic [ADDR_W:0]   peak_level;
`endif

    int unsigned n_asserts = 0;
    int unsigned n_fail    = 0;

    // Reference model state
    logic [31:0] sb_q[$];
    logic [31:0] m_rd   = '0;
    logic        m_ovf  = 1'b0;
    logic        m_unf  = 1'b0;
    int          m_peak = 0;

    conv_output_fifo #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .AF_MARGIN (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef FIFO_PEAK_EN
        ,
        .peak_level  (peak_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        int sz;
        sz = sb_q.size();
        chk({step, ":level"},       32'(level),       32'(sz));
        chk({step, ":fifo_empty"},  32'(fifo_empty),  32'(sz == 0));
        chk({step, ":fifo_full"},   32'(fifo_full),   32'(sz == DEPTH));
        chk({step, ":almost_full"}, 32'(almost_full), 32'(sz >= AF_LVL));
        chk({step, ":rd_data"},     rd_data,          m_rd);
        chk({step, ":overflow"},    32'(overflow),    32'(m_ovf));
        chk({step, ":underflow"},   32'(underflow),   32'(m_unf));
`ifdef FIFO_PEAK_EN
        chk({step, ":peak_level"},  32'(peak_level),  32'(m_peak));
`endif
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_rd   = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_peak = 0;
    endtask

    // One clock: drive, advance the model, then sample 1 ns after the edge.
    task automatic cycle(input string step, input logic w, input logic [31:0] d,
                         input logic r, input logic c);
        bit full;
        bit empty;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clear   = c;
        full    = (sb_q.size() == DEPTH);
        empty   = (sb_q.size() == 0);
        if (c) begin
            sb_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_peak = 0;
        end else begin
            if (w && full && !r) m_ovf = 1'b1;
            if (r && empty)      m_unf = 1'b1;
            if (r && !empty)     m_rd  = sb_q.pop_front();
            if (w && (!full || r)) sb_q.push_back(d);
            if (sb_q.size() > m_peak) m_peak = sb_q.size();
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
        check_all(step);
    endtask

    initial begin
        rst     = 1'b0;
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        // 1: ten words through, each read visible the cycle after rd_en
        for (int i = 0; i < 10; i++) cycle("t1_wr", 1'b1, 32'h11 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("t1_rd", 1'b0, '0, 1'b1, 1'b0);
        chk("t1_last_word", rd_data, 32'h1A);

        // 2: fill to full, then a dropped write sets overflow
        for (int i = 0; i < 16; i++) cycle("t2_fill", 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        cycle("t2_drop", 1'b1, 32'hDEAD, 1'b0, 1'b0);

        // 3: streaming while full across pointer wrap, then drain
        for (int i = 0; i < 20; i++) cycle("t3_both", 1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cycle("t3_drain", 1'b0, '0, 1'b1, 1'b0);
        chk("t3_last_word", rd_data, 32'h213);

        // 4: underflow on empty, no fall-through with a same-cycle write
        cycle("t4_rd_empty", 1'b0, '0, 1'b1, 1'b0);
        cycle("t4_wr_rd_empty", 1'b1, 32'hAB, 1'b1, 1'b0);
        cycle("t4_rd_ab", 1'b0, '0, 1'b1, 1'b0);
        chk("t4_ab", rd_data, 32'hAB);

        // 5: clear beats a same-cycle write; async reset mid-burst
        for (int i = 0; i < 7; i++) cycle("t5_wr", 1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        cycle("t5_clear", 1'b1, 32'h3FF, 1'b0, 1'b1);
        cycle("t5_idle_rd_hold", 1'b0, '0, 1'b0, 1'b0);
        cycle("t5_wr_after", 1'b1, 32'h55, 1'b0, 1'b0);
        cycle("t5_rd_after", 1'b0, '0, 1'b1, 1'b0);
        chk("t5_clear_discard", rd_data, 32'h55);
        for (int i = 0; i < 5; i++) cycle("t5_burst", 1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
        wr_en   = 1'b1;
        wr_data = 32'h4FF;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("t5_async_rst");
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("t5_after_rst");

`ifdef FIFO_PEAK_EN
        // 6: peak tracker
        for (int i = 0; i < 12; i++) cycle("t6_wr", 1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle("t6_rd", 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)  cycle("t6_wr3", 1'b1, 32'h600 + 32'(i), 1'b0, 1'b0);
        chk("t6_peak12", 32'(peak_level), 32'd12);
        cycle("t6_clear", 1'b0, '0, 1'b0, 1'b1);
        chk("t6_peak0", 32'(peak_level), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_conv_output_fifo
